// File: rtl/tapped_delay_line.sv
// Runtime-programmable delay line: data_out at cycle t is {in_valid, data_in} from cycle t-d, d in 1..DEPTH.
// Optional macro TAPPED_DELAY_FLUSH_EN adds a `flush` input that restarts fill gating without moving wp.
module tapped_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DLY_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TAPPED_DELAY_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DLY_W-1:0]      delay,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  delay_err
);

  // Valid-only streaming: no backpressure. in_valid qualifies data_in in its cycle,
  // and out_valid qualifies data_out in its cycle; a low valid is a bubble that is carried through.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = DLY_W + 1;
  localparam logic [DLY_W-1:0] DEPTH_D = DLY_W'(DEPTH);
  localparam logic [DLY_W-1:0] ONE_D   = DLY_W'(1);
  localparam logic [PW-1:0]    LAST_WP = PW'(DEPTH - 1);
  localparam logic [IW-1:0]    DEPTH_I = IW'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PW-1:0]       wp;
  logic [DLY_W-1:0]    fill;
  logic [DLY_W-1:0]    fill_next;
  logic [DLY_W-1:0]    d;
  logic                bad_delay;
  logic [IW-1:0]       idx_raw;
  logic [PW-1:0]       rd_idx;
  logic                flush_now;

`ifdef TAPPED_DELAY_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // The output register is itself one tick of delay, so the tap looks d-1 entries back
  // from the slot being written; d = 1 bypasses the buffer entirely.
  always_comb begin
    bad_delay = (delay == '0) || (delay > DEPTH_D);
    if (delay == '0) begin
      d = ONE_D;
    end else if (delay > DEPTH_D) begin
      d = DEPTH_D;
    end else begin
      d = delay;
    end
    fill_next = (fill == DEPTH_D) ? fill : fill + ONE_D;
    idx_raw   = IW'(wp) + DEPTH_I - IW'(d) + IW'(1);
    rd_idx    = PW'((idx_raw >= DEPTH_I) ? idx_raw - DEPTH_I : idx_raw);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[wp] <= {in_valid, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      delay_err <= 1'b0;
    end else begin
      wp <= (wp == LAST_WP) ? '0 : wp + 1'b1;
      if (bad_delay) begin
        delay_err <= 1'b1;
      end
      if (flush_now) begin
        fill      <= ONE_D;
        out_valid <= 1'b0;
        data_out  <= '0;
      end else begin
        fill <= fill_next;
        if (fill_next < d) begin
          out_valid <= 1'b0;
          data_out  <= '0;
        end else if (d == ONE_D) begin
          out_valid <= in_valid;
          data_out  <= data_in;
        end else begin
          {out_valid, data_out} <= mem[rd_idx];
        end
      end
    end
  end

endmodule
